overlay_io_ctrl: RTL and testbench

//  Parametrised I/O controller for the PE-array overlay, replacing the fixed SIPO/PISO pair.
//  - Collects PE_NUM serial words into a broadcast lane bus and pulses the PE array.
//  - Captures the array's parallel result when the PEs signal completion.
//  - Drains the result serially with a valid/ready handshake.
//  - Sits between the overlay's streaming ports and the PE chain.

---
 rtl/overlay_io_ctrl.sv | 167 ++++++++++++++++
 tb/tb_overlay_io_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_io_ctrl.sv
// overlay_io_ctrl: parametrised serial <-> parallel I/O controller for the
// PE-array overlay. Gathers PE_NUM serial words into a broadcast lane bus,
// pulses the array, captures its parallel result and drains it serially
// over a valid/ready handshake.
// Optional feature macro: DRAIN_MASK_EN (adds drain_mask lane selection).
module overlay_io_ctrl #(
    parameter int DATA_W = 32,
    parameter int PE_NUM = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     s_in_v,
    input  logic [DATA_W-1:0]        s_in,
    output logic                     s_in_rdy,
    output logic                     pe_in_v,
    output logic [PE_NUM*DATA_W-1:0] pe_in,
    input  logic                     pe_out_v,
    input  logic [PE_NUM*DATA_W-1:0] pe_out,
`ifdef DRAIN_MASK_EN
    input  logic [PE_NUM-1:0]        drain_mask,
`endif
    output logic                     m_out_v,
    output logic [DATA_W-1:0]        m_out,
    output logic                     m_out_last,
    input  logic                     m_out_rdy,
    output logic                     err
);

    localparam int CNT_W = $clog2(PE_NUM);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  lane_in_q  [PE_NUM];
    logic [DATA_W-1:0]  lane_in_d  [PE_NUM];
    logic [DATA_W-1:0]  lane_out_q [PE_NUM];
    logic [DATA_W-1:0]  lane_out_d [PE_NUM];
    logic [DATA_W-1:0]  pe_out_lane [PE_NUM];
    logic               err_q, err_d;
    logic [PE_NUM-1:0]  capture_mask;
    logic [PE_NUM-1:0]  lane_mask;
    logic [CNT_W:0]     nxt_lane;
    logic [CNT_W:0]     first_lane;

    // Lane packing between flat buses and per-lane arrays
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
        assign pe_out_lane[gi]                 = pe_out[gi*DATA_W +: DATA_W];
        assign pe_in[gi*DATA_W +: DATA_W]      = lane_in_q[gi];
    end

`ifdef DRAIN_MASK_EN
    logic [PE_NUM-1:0] mask_q, mask_d;
    assign capture_mask = drain_mask;
    assign lane_mask    = mask_q;

    // Drain mask register, sampled together with the result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mask_q <= '0;
        else      mask_q <= mask_d;
    end
`else
    assign capture_mask = '1;
    assign lane_mask    = '1;
`endif

    // Lowest enabled lane at or above 'from'; MSB flags that one exists
    function automatic logic [CNT_W:0] find_lane(input logic [PE_NUM-1:0] mask,
                                                 input int from);
        logic [CNT_W:0] r;
        r = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, CNT_W'(i)};
        end
        return r;
    endfunction

    // State, counter, lane registers and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < PE_NUM; i++) begin
                lane_in_q[i]  <= '0;
                lane_out_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            lane_in_q  <= lane_in_d;
            lane_out_q <= lane_out_d;
        end
    end

    // Next-state and output decode; ce=0 leaves every register untouched
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        lane_in_d  = lane_in_q;
        lane_out_d = lane_out_q;
`ifdef DRAIN_MASK_EN
        mask_d     = mask_q;
`endif
        s_in_rdy   = 1'b0;
        pe_in_v    = (state_q == ISSUE);
        m_out_v    = (state_q == DRAIN);
        m_out      = lane_out_q[cnt_q];
        nxt_lane   = find_lane(lane_mask, int'(cnt_q) + 1);
        first_lane = find_lane(capture_mask, 0);
        m_out_last = (state_q == DRAIN) && !nxt_lane[CNT_W];

        if (ce) begin
            // A result strobe outside WAIT is a protocol violation
            if (pe_out_v && (state_q != WAIT)) err_d = 1'b1;

            case (state_q)
                FILL: begin
                    s_in_rdy = 1'b1;
                    if (s_in_v) begin
                        lane_in_d[cnt_q] = s_in;
                        if (cnt_q == CNT_W'(PE_NUM - 1)) begin
                            cnt_d   = '0;
                            state_d = ISSUE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (pe_out_v) begin
                        lane_out_d = pe_out_lane;
`ifdef DRAIN_MASK_EN
                        mask_d     = capture_mask;
`endif
                        // Empty selection skips the drain entirely
                        if (first_lane[CNT_W]) begin
                            cnt_d   = first_lane[CNT_W-1:0];
                            state_d = DRAIN;
                        end else begin
                            cnt_d   = '0;
                            state_d = FILL;
                        end
                    end
                end
                DRAIN: begin
                    if (m_out_rdy) begin
                        if (nxt_lane[CNT_W]) begin
                            cnt_d = nxt_lane[CNT_W-1:0];
                        end else begin
                            cnt_d   = '0;
                            state_d = FILL;
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_overlay_io_ctrl.sv
// Testbench for overlay_io_ctrl (PE_NUM=4, DATA_W=32); scoreboard-based.
module tb_overlay_io_ctrl;

    localparam int DW = 32;
    localparam int PN = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ce = 1'b1;
    logic             s_in_v = 1'b0;
    logic [DW-1:0]    s_in = '0;
    logic             s_in_rdy;
    logic             pe_in_v;
    logic [PN*DW-1:0] pe_in;
    logic             pe_out_v = 1'b0;
    logic [PN*DW-1:0] pe_out = '0;
    logic             m_out_v;
    logic [DW-1:0]    m_out;
    logic             m_out_last;
    logic             m_out_rdy = 1'b0;
    logic             err;
`ifdef DRAIN_MASK_EN
    logic [PN-1:0]    drain_mask = '1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;
    exp_t sb[$];

    overlay_io_ctrl #(.DATA_W(DW), .PE_NUM(PN)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .s_in_v(s_in_v), .s_in(s_in), .s_in_rdy(s_in_rdy),
        .pe_in_v(pe_in_v), .pe_in(pe_in),
        .pe_out_v(pe_out_v), .pe_out(pe_out),
`ifdef DRAIN_MASK_EN
        .drain_mask(drain_mask),
`endif
        .m_out_v(m_out_v), .m_out(m_out), .m_out_last(m_out_last),
        .m_out_rdy(m_out_rdy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (pe_in !== '0)      begin errors++; $display("FAIL reset_pe_in got=%h exp=0", pe_in); end
        checks++; if (pe_in_v !== 1'b0)  begin errors++; $display("FAIL reset_pe_in_v got=%b exp=0", pe_in_v); end
        checks++; if (m_out !== '0)      begin errors++; $display("FAIL reset_m_out got=%h exp=0", m_out); end
        checks++; if (m_out_v !== 1'b0)  begin errors++; $display("FAIL reset_m_out_v got=%b exp=0", m_out_v); end
        checks++; if (m_out_last !== 1'b0) begin errors++; $display("FAIL reset_m_out_last got=%b exp=0", m_out_last); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        $display("reset: outputs checked");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", s_in_rdy); end
    endtask

    // Offer n words; for a full batch check the issue pulse and lane bus
    task automatic send_words(input logic [DW-1:0] w [PN], input int n);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 40) begin
            @(negedge clk);
            s_in_v = 1'b1;
            s_in   = w[idx];
            #1;
            if (s_in_rdy) begin
                $display("send: word %0d = %h", idx, w[idx]);
                idx++;
            end
            guard++;
        end
        checks++;
        if (idx < n) begin errors++; $display("FAIL send_timeout accepted=%0d exp=%0d", idx, n); end
        @(negedge clk);
        s_in_v = 1'b0;
        s_in   = '0;
        if (n == PN) begin
            #1;
            checks++; if (pe_in_v !== 1'b1) begin errors++; $display("FAIL issue_pulse got=%b exp=1", pe_in_v); end
            checks++; if (pe_in !== {w[3], w[2], w[1], w[0]})
                begin errors++; $display("FAIL pe_in_bus got=%h exp=%h", pe_in, {w[3], w[2], w[1], w[0]}); end
            checks++; if (s_in_rdy !== 1'b0) begin errors++; $display("FAIL rdy_after_fill got=%b exp=0", s_in_rdy); end
            @(negedge clk);
            #1;
            checks++; if (pe_in_v !== 1'b0) begin errors++; $display("FAIL issue_one_cycle got=%b exp=0", pe_in_v); end
            checks++; if (s_in_rdy !== 1'b0) begin errors++; $display("FAIL rdy_in_wait got=%b exp=0", s_in_rdy); end
        end
    endtask

    // Pulse the result strobe in WAIT and push the expected drain sequence
    task automatic capture(input logic [DW-1:0] lanes [PN], input logic [PN-1:0] mask);
        int hi = -1;
        @(negedge clk);
        pe_out_v = 1'b1;
        pe_out   = {lanes[3], lanes[2], lanes[1], lanes[0]};
`ifdef DRAIN_MASK_EN
        drain_mask = mask;
`endif
        for (int k = 0; k < PN; k++) if (mask[k]) hi = k;
        for (int k = 0; k < PN; k++) if (mask[k]) sb.push_back('{lanes[k], (k == hi)});
        $display("capture: bus=%h mask=%b", pe_out, mask);
        @(negedge clk);
        pe_out_v = 1'b0;
    endtask

    // Drain the scoreboard with a cyclic ready pattern, optional ce freeze
    task automatic drain(input logic [7:0] pat, input int freeze_at);
        int i = 0;
        int guard = 0;
        exp_t e;
        while (sb.size() > 0 && guard < 100) begin
            #1;
            e = sb[0];
            checks++; if (m_out_v !== 1'b1) begin errors++; $display("FAIL drain_valid got=%b exp=1", m_out_v); end
            checks++; if (m_out !== e.d) begin errors++; $display("FAIL drain_data got=%h exp=%h", m_out, e.d); end
            checks++; if (m_out_last !== e.last) begin errors++; $display("FAIL drain_last got=%b exp=%b", m_out_last, e.last); end
            if (i == freeze_at) begin
                ce = 1'b0;
                m_out_rdy = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    checks++; if (m_out_v !== 1'b1 || m_out !== e.d)
                        begin errors++; $display("FAIL ce_freeze got=%b/%h exp=1/%h", m_out_v, m_out, e.d); end
                end
                ce = 1'b1;
                $display("drain: ce held low 3 cycles at lane word %h", e.d);
            end
            m_out_rdy = pat[i % 8];
            if (m_out_rdy) begin
                void'(sb.pop_front());
                $display("drain: word %h last=%b", e.d, e.last);
            end
            i++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_timeout left=%0d exp=0", sb.size()); end
        #1;
        m_out_rdy = 1'b0;
        checks++; if (m_out_v !== 1'b0) begin errors++; $display("FAIL drain_end_valid got=%b exp=0", m_out_v); end
        checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL drain_end_rdy got=%b exp=1", s_in_rdy); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] w [PN] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [DW-1:0] r [PN] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        send_words(w, PN);
        capture(r, 4'hF);
        drain(8'hFF, -1);
    endtask

    task automatic test_stall();
        logic [DW-1:0] w [PN] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
        logic [DW-1:0] r [PN] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
        send_words(w, PN);
        capture(r, 4'hF);
        drain(8'b1001_1001, -1);
    endtask

    task automatic test_reset_mid_fill();
        logic [DW-1:0] p [PN] = '{32'hDEAD_0001, 32'hDEAD_0002, 32'h0, 32'h0};
        logic [DW-1:0] w [PN] = '{32'h5, 32'h6, 32'h7, 32'h8};
        send_words(p, 2);
        rst = 1'b0;
        #1;
        checks++; if (pe_in !== '0) begin errors++; $display("FAIL midreset_pe_in got=%h exp=0", pe_in); end
        checks++; if (m_out_v !== 1'b0 || pe_in_v !== 1'b0)
            begin errors++; $display("FAIL midreset_valids got=%b%b exp=00", m_out_v, pe_in_v); end
        @(negedge clk);
        rst = 1'b1;
        send_words(w, PN);
        capture(w, 4'hF);
        drain(8'hFF, -1);
    endtask

    task automatic test_err_ce();
        logic [DW-1:0] w [PN] = '{32'h100, 32'h200, 32'h300, 32'h400};
        logic [DW-1:0] r [PN] = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
        @(negedge clk);
        pe_out_v = 1'b1;
        pe_out   = '1;
        @(negedge clk);
        pe_out_v = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", err); end
        checks++; if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL err_fill_kept got=%b exp=1", s_in_rdy); end
        $display("err: stray strobe in FILL, err=%b", err);
        send_words(w, PN);
        capture(r, 4'hF);
        drain(8'hFF, 1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

`ifdef DRAIN_MASK_EN
    task automatic test_mask();
        logic [DW-1:0] w [PN] = '{32'h71, 32'h72, 32'h73, 32'h74};
        logic [DW-1:0] r [PN] = '{32'hAA0, 32'hAA1, 32'hAA2, 32'hAA3};
        send_words(w, PN);
        capture(r, 4'b1010);
        drain(8'hFF, -1);
        send_words(w, PN);
        capture(r, 4'b0000);
        drain(8'hFF, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid_fill();
        test_err_ce();
`ifdef DRAIN_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
